hdmi_video_timing: RTL and testbench
====================================

# hdmi_video_timing

Raster timing and pixel-address generator for the HDMI output path, clocked by the 25 MHz pixel clock. It produces the DE/HSYNC/VSYNC timing for the ADV7513 video input and the read address for the image ROM, which sits downstream of this block. It also delays the sync/enable strobes so they line up with the ROM's registered read data. Raster start is gated by an enable, driven by I2C configuration completion.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HS_POL / VS_POL, 0 / 0, active level of HSYNC / VSYNC
- IMG_W / IMG_H, 320 / 240, image window size in pixels
- IMG_X0 / IMG_Y0, 160 / 120, window top-left corner; IMG_X0+IMG_W ≤ H_ACTIVE, IMG_Y0+IMG_H ≤ V_ACTIVE
- ADDR_WIDTH, 19, PX_ADDR width; IMG_W*IMG_H ≤ 2^ADDR_WIDTH
- LAT, 2, ROM read latency in pixel clocks (0..7)
- CLK_PX  in  1  pixel clock
- RST_n  in  1  synchronous, active-low reset
- EN  in  1  raster enable (configuration done)
- PX_ADDR  out  ADDR_WIDTH  image ROM read address
- DE  out  1  data enable, aligned to ROM data
- HSYNC  out  1  horizontal sync, aligned to ROM data
- VSYNC  out  1  vertical sync, aligned to ROM data
- IN_IMG  out  1  current output pixel lies inside the image window (caller muxes ROM data vs background)
- FRAME_START  out  1  one-cycle pulse on the output pixel (0,0)

## Operation
- Counters h (0..H_TOTAL−1) and v (0..V_TOTAL−1), each 11 bits.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
  - Line order is active, front porch, sync, back porch.
  - h wraps to 0 and v increments on the same cycle; v wraps to 0 after V_TOTAL−1.
- active = (h < H_ACTIVE) && (v < V_ACTIVE).
- hs_raw asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- vs_raw asserted for whole lines V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. VSYNC edges coincide with h=0.
- win = active && IMG_X0 ≤ h < IMG_X0+IMG_W && IMG_Y0 ≤ v < IMG_Y0+IMG_H.
- Address generation is incremental; no multiplier is used.
  - An address counter cleared at (h,v)=(0,0) increments after each win pixel.
  - PX_ADDR is the counter value when win is true, and 0 otherwise.
  - The last window pixel yields IMG_W*IMG_H−1.
- Enable behaviour:
  - EN low from reset: counters hold at (0,0) and all outputs stay at idle values.
  - EN sampled high: counting starts at the next cycle.
  - EN dropped mid-frame: the current frame completes, then the counters hold at (0,0) until EN is high again.
- Polarity: HSYNC = hs ? HS_POL : ~HS_POL; VSYNC is formed the same way with VS_POL.

## Timing
- Define cycle t as the cycle in which the counters hold (h,v).
- PX_ADDR for (h,v) is registered and valid at t+1.
- DE, HSYNC, VSYNC, IN_IMG and FRAME_START for (h,v) are valid at t+1+LAT. They pass through a LAT-stage delay line after the output register, so they align with ROM q.
- Reset values: PX_ADDR=0, DE=0, IN_IMG=0, FRAME_START=0, HSYNC=~HS_POL, VSYNC=~VS_POL. Counters and the address counter reset to 0.
- Every delay-line stage resets to the idle values, so no stale DE/sync appears after reset.
- Reset mid-frame: one cycle after RST_n is sampled low, all outputs are at their reset values. After release, the raster restarts from (0,0) if EN is high.
- Idle-hold cycles (EN low) inject idle values into the delay line.
- Defaults give 800 cycles per line and 525 lines, i.e. 420000 cycles per frame.

## Test plan
- Reset: hold RST_n low 5 cycles with EN=1 -> DE=0, HSYNC=1, VSYNC=1, PX_ADDR=0, IN_IMG=0, and all stay so through cycle LAT+1 after release.
- Line timing: EN=1, defaults -> DE high exactly 640 cycles, period 800. HSYNC low 96 cycles, falling 656 cycles after the DE rise.
- Frame timing: -> 480 DE lines per frame. VSYNC low exactly 1600 cycles, starting at the line-490 h=0 output. FRAME_START pulses every 420000 cycles, in the same cycle as the first DE rise.
- Address/window: defaults, LAT=2.
  - PX_ADDR=0 at h=160, v=120; 319 at h=479; 320 at h=160, v=121; 76799 at h=479, v=359; 0 elsewhere.
  - The IN_IMG rise is exactly 2 cycles after the address-0 cycle.
- EN drop: deassert EN at line 200 -> the frame runs to v=524, h=799, then outputs stay idle with no FRAME_START. Reassert EN -> FRAME_START occurs 2+LAT cycles later.
- Reset mid-frame: RST_n low 1 cycle during line 300 active video -> DE=0 on the next cycle with no residual DE from the delay line. After release with EN=1, the first FRAME_START arrives 1+LAT cycles later.

Source files
------------

// File: rtl/hdmi_video_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_video_timing_if
// Description : Video timing bundle between the raster generator (master)
//               and the HDMI output path / image ROM side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_video_timing_if #(
   parameter int ADDR_WIDTH = 19
);
   logic                  en;           // raster enable (configuration done)
   logic [ADDR_WIDTH-1:0] px_addr;      // image ROM read address
   logic                  de;           // data enable, aligned to ROM data
   logic                  hsync;        // horizontal sync, aligned to ROM data
   logic                  vsync;        // vertical sync, aligned to ROM data
   logic                  in_img;       // output pixel lies inside image window
   logic                  frame_start;  // pulse on output pixel (0,0)

   modport master (
      input  en,
      output px_addr, de, hsync, vsync, in_img, frame_start
   );

   modport slave (
      output en,
      input  px_addr, de, hsync, vsync, in_img, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/hdmi_video_timing.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_video_timing
// Description : Raster timing and incremental image-ROM address generator.
//               Sync/enable strobes are delayed LAT cycles beyond the address
//               register so they line up with the ROM's registered read data.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_video_timing #(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int IMG_W      = 320,
   parameter int IMG_H      = 240,
   parameter int IMG_X0     = 160,
   parameter int IMG_Y0     = 120,
   parameter int ADDR_WIDTH = 19,
   parameter int LAT        = 2
) (
   input  wire logic               clk_px_i,
   input  wire logic               rst_n_i,
   hdmi_video_timing_if.master     bus_io
);

   localparam logic [10:0] C_H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] C_V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] C_HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] C_VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] C_X0       = 11'(IMG_X0);
   localparam logic [10:0] C_X1       = 11'(IMG_X0 + IMG_W);
   localparam logic [10:0] C_Y0       = 11'(IMG_Y0);
   localparam logic [10:0] C_Y1       = 11'(IMG_Y0 + IMG_H);

   // strobe vector bit positions; all-zero is the idle (inactive) pattern
   localparam int C_B_DE = 0;
   localparam int C_B_HS = 1;
   localparam int C_B_VS = 2;
   localparam int C_B_IM = 3;
   localparam int C_B_FS = 4;

   logic [10:0]           h_q, h_d;
   logic [10:0]           v_q, v_d;
   logic [ADDR_WIDTH-1:0] acnt_q, acnt_d;
   logic [ADDR_WIDTH-1:0] px_addr_q, px_addr_d;
   logic [4:0]            stb_q, stb_d;
   logic                  en_q;

   logic                  w_origin;
   logic                  w_run;
   logic                  w_h_last;
   logic                  w_v_last;
   logic                  w_active;
   logic                  w_hs;
   logic                  w_vs;
   logic                  w_win;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [4:0]            w_stb_out;

   // EN sampler; only the origin hold decision looks at it, so no reset needed
   always_ff @(posedge clk_px_i) begin
      en_q <= bus_io.en;
   end

   // Raster decode, counter advance and incremental address next-state
   always_comb begin
      w_origin = (h_q == 11'd0) && (v_q == 11'd0);
      // counting only pauses at the origin; a frame in progress always completes
      w_run    = !w_origin || en_q;
      w_h_last = (h_q == C_H_LAST);
      w_v_last = (v_q == C_V_LAST);
      w_active = (h_q < C_H_ACT) && (v_q < C_V_ACT);
      w_hs     = (h_q >= C_HS_START) && (h_q < C_HS_END);
      w_vs     = (v_q >= C_VS_START) && (v_q < C_VS_END);
      w_win    = w_active && (h_q >= C_X0) && (h_q < C_X1)
                          && (v_q >= C_Y0) && (v_q < C_Y1);
      // address counter is logically cleared at the origin of every frame
      w_addr   = w_origin ? '0 : acnt_q;

      h_d       = h_q;
      v_d       = v_q;
      acnt_d    = acnt_q;
      stb_d     = '0;
      px_addr_d = '0;
      if (w_run) begin
         h_d = w_h_last ? 11'd0 : h_q + 11'd1;
         if (w_h_last) begin
            v_d = w_v_last ? 11'd0 : v_q + 11'd1;
         end
         acnt_d    = w_win ? w_addr + ADDR_WIDTH'(1) : w_addr;
         px_addr_d = w_win ? w_addr : '0;
         stb_d[C_B_DE] = w_active;
         stb_d[C_B_HS] = w_hs;
         stb_d[C_B_VS] = w_vs;
         stb_d[C_B_IM] = w_win;
         stb_d[C_B_FS] = w_origin;
      end
   end

   // Counters and first output register stage
   always_ff @(posedge clk_px_i) begin
      if (!rst_n_i) begin
         h_q       <= 11'd0;
         v_q       <= 11'd0;
         acnt_q    <= '0;
         px_addr_q <= '0;
         stb_q     <= '0;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         acnt_q    <= acnt_d;
         px_addr_q <= px_addr_d;
         stb_q     <= stb_d;
      end
   end

   generate
      if (LAT > 0) begin : g_dly
         logic [4:0] dly_q [LAT];

         // Strobe delay line matching ROM read latency; every stage resets idle
         always_ff @(posedge clk_px_i) begin
            if (!rst_n_i) begin
               for (int i = 0; i < LAT; i++) begin
                  dly_q[i] <= '0;
               end
            end else begin
               dly_q[0] <= stb_q;
               for (int i = 1; i < LAT; i++) begin
                  dly_q[i] <= dly_q[i-1];
               end
            end
         end

         assign w_stb_out = dly_q[LAT-1];
      end else begin : g_nodly
         assign w_stb_out = stb_q;
      end
   endgenerate

   assign bus_io.px_addr     = px_addr_q;
   assign bus_io.de          = w_stb_out[C_B_DE];
   assign bus_io.hsync       = w_stb_out[C_B_HS] ? HS_POL : ~HS_POL;
   assign bus_io.vsync       = w_stb_out[C_B_VS] ? VS_POL : ~VS_POL;
   assign bus_io.in_img      = w_stb_out[C_B_IM];
   assign bus_io.frame_start = w_stb_out[C_B_FS];

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_video_timing
// Description : Scoreboard bench for hdmi_video_timing on a reduced raster
//               (25 x 18 totals, 6 x 4 window at (4,3), LAT=2, 450-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_video_timing;

   localparam int HA  = 16;
   localparam int HFP = 2;
   localparam int HSY = 3;
   localparam int HBP = 4;
   localparam int HT  = HA + HFP + HSY + HBP;   // 25
   localparam int VA  = 12;
   localparam int VFP = 1;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int VT  = VA + VFP + VSY + VBP;   // 18
   localparam int FR  = HT * VT;                // 450
   localparam int IW  = 6;
   localparam int IH  = 4;
   localparam int X0  = 4;
   localparam int Y0  = 3;
   localparam int AW  = 19;
   localparam int LAT = 2;

   // directed stimulus schedule (cycle numbers of the drive cycle)
   localparam int RST_REL = 4;      // reset driven low in cycles 0..3 -> 5 reset edges
   localparam int EN_OFF  = 1059;   // frame 2, line 6
   localparam int EN_ON   = 1400;   // after frame 2 has completed and held
   localparam int RST2    = 1606;   // frame 3, line 8 active video
   localparam int K_END   = 2550;

   // directed signal codes
   localparam int S_ADDR = 0;
   localparam int S_DE   = 1;
   localparam int S_HS   = 2;
   localparam int S_VS   = 3;
   localparam int S_IM   = 4;
   localparam int S_FS   = 5;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   hdmi_video_timing_if #(.ADDR_WIDTH(AW)) vif ();

   hdmi_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .HS_POL(1'b0), .VS_POL(1'b0),
      .IMG_W(IW), .IMG_H(IH), .IMG_X0(X0), .IMG_Y0(Y0),
      .ADDR_WIDTH(AW), .LAT(LAT)
   ) dut (
      .clk_px_i (clk),
      .rst_n_i  (rst_n),
      .bus_io   (vif)
   );

   typedef struct {
      int cyc;
      int addr;
      bit de;
      bit hs;
      bit vs;
      bit im;
      bit fs;
   } exp_t;

   typedef struct {
      int cyc;
      int sig;
      int val;
   } dir_t;

   exp_t sb[$];
   dir_t dq[$];
   int   checks   = 0;
   int   failures = 0;
   int   mcyc     = -1;

   // stimulus-side raster model
   int   pos      = 0;
   int   last_rst = -1;
   bit   rst_prev = 1'b0;
   bit   en_prev  = 1'b1;
   bit   run_prev = 1'b0;
   bit   enq;
   bit   run;
   int   src[$];
   int   j;
   exp_t e_a;
   exp_t e_s;
   exp_t e_n;

   // expected output levels for raster pixel index p (p < 0: idle)
   function automatic exp_t pix(input int p);
      exp_t e;
      int   h;
      int   v;
      bit   act;
      bit   win;
      e.cyc  = 0;
      e.addr = 0;
      e.de   = 1'b0;
      e.hs   = 1'b1;
      e.vs   = 1'b1;
      e.im   = 1'b0;
      e.fs   = 1'b0;
      if (p >= 0) begin
         h    = p % HT;
         v    = p / HT;
         act  = (h < HA) && (v < VA);
         win  = act && (h >= X0) && (h < X0 + IW) && (v >= Y0) && (v < Y0 + IH);
         e.de = act;
         e.hs = !((h >= HA + HFP) && (h < HA + HFP + HSY));
         e.vs = !((v >= VA + VFP) && (v < VA + VFP + VSY));
         e.im = win;
         e.fs = (p == 0);
         e.addr = win ? (v - Y0) * IW + (h - X0) : 0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input int cyc, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic add_dir(input int cyc, input int sig, input int val);
      dir_t d;
      d.cyc = cyc;
      d.sig = sig;
      d.val = val;
      dq.push_back(d);
   endtask

   // stimulus + expected-response producer
   initial begin
      rst_n  = 1'b0;
      vif.en = 1'b1;

      // hand-computed spot values, ascending cycle order
      add_dir(3,    S_ADDR, 0);  add_dir(3, S_DE, 0); add_dir(3, S_HS, 1);
      add_dir(3,    S_VS, 1);    add_dir(3, S_IM, 0); add_dir(3, S_FS, 0);
      add_dir(6,    S_DE, 0);    add_dir(6, S_HS, 1);
      add_dir(7,    S_DE, 1);    add_dir(7, S_FS, 1);
      add_dir(8,    S_FS, 0);
      add_dir(22,   S_DE, 1);    add_dir(23, S_DE, 0);
      add_dir(24,   S_HS, 1);    add_dir(25, S_HS, 0);
      add_dir(27,   S_HS, 0);    add_dir(28, S_HS, 1);
      add_dir(84,   S_ADDR, 0);
      add_dir(85,   S_ADDR, 1);  add_dir(85, S_IM, 0);
      add_dir(86,   S_IM, 1);
      add_dir(89,   S_ADDR, 5);  add_dir(90, S_ADDR, 0);
      add_dir(109,  S_ADDR, 6);  add_dir(164, S_ADDR, 23);
      add_dir(331,  S_VS, 1);    add_dir(332, S_VS, 0);
      add_dir(381,  S_VS, 0);    add_dir(382, S_VS, 1);
      add_dir(457,  S_FS, 1);
      add_dir(1357, S_FS, 0);
      add_dir(1403, S_FS, 0);    add_dir(1404, S_FS, 1);
      add_dir(1606, S_DE, 1);
      add_dir(1607, S_DE, 0);    add_dir(1607, S_HS, 1); add_dir(1607, S_ADDR, 0);
      add_dir(1608, S_DE, 0);
      add_dir(1609, S_DE, 0);    add_dir(1609, S_FS, 0);
      add_dir(1610, S_FS, 1);

      for (int k = 0; k < K_END; k++) begin
         @(posedge clk);
         #1;
         // raster position held during cycle k
         if (!rst_prev) begin
            pos      = 0;
            last_rst = k;
         end else if (run_prev) begin
            pos = (pos + 1) % FR;
         end
         enq = en_prev;
         run = (pos != 0) || enq;
         src.push_back(run ? pos : -1);

         rst_n  = !((k < RST_REL) || (k == RST2));
         vif.en = !((k >= EN_OFF) && (k < EN_ON));

         // expected outputs for cycle k+1
         if (!rst_n) begin
            e_n = pix(-1);
         end else begin
            e_a = pix(src[k]);
            j   = k - LAT;
            if ((j < 0) || (last_rst >= j + 1)) e_s = pix(-1);
            else                                e_s = pix(src[j]);
            e_n      = e_s;
            e_n.addr = e_a.addr;
         end
         e_n.cyc = k + 1;
         sb.push_back(e_n);

         rst_prev = rst_n;
         en_prev  = vif.en;
         run_prev = run;
      end

      repeat (4) @(negedge clk);
      if (dq.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL directed_pending actual=%0d required=0", dq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // monitor: samples mid-cycle and retires scoreboard entries
   initial begin
      exp_t e;
      dir_t d;
      logic [31:0] act;
      forever begin
         @(negedge clk);
         mcyc++;
         if ((sb.size() > 0) && (sb[0].cyc == mcyc)) begin
            e = sb.pop_front();
            chk("px_addr",     mcyc, 32'(vif.px_addr),     32'(e.addr));
            chk("de",          mcyc, 32'(vif.de),          32'(e.de));
            chk("hsync",       mcyc, 32'(vif.hsync),       32'(e.hs));
            chk("vsync",       mcyc, 32'(vif.vsync),       32'(e.vs));
            chk("in_img",      mcyc, 32'(vif.in_img),      32'(e.im));
            chk("frame_start", mcyc, 32'(vif.frame_start), 32'(e.fs));
         end
         while ((dq.size() > 0) && (dq[0].cyc == mcyc)) begin
            d = dq.pop_front();
            case (d.sig)
               S_ADDR:  act = 32'(vif.px_addr);
               S_DE:    act = 32'(vif.de);
               S_HS:    act = 32'(vif.hsync);
               S_VS:    act = 32'(vif.vsync);
               S_IM:    act = 32'(vif.in_img);
               default: act = 32'(vif.frame_start);
            endcase
            chk($sformatf("directed_sig%0d", d.sig), mcyc, act, 32'(d.val));
         end
      end
   end

endmodule
`default_nettype wire
